// File: rtl/axi_lite_bram_bridge.sv
// AXI4-Lite slave that bridges single-beat reads and writes onto a handshaked word memory port.
// Define BRIDGE_WSTRB_EN to honour write strobes with a read-modify-write on partial writes.
module axi_lite_bram_bridge #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic        mem_done
);

  typedef enum logic [2:0] {
    IDLE, WCOLLECT, RMW_RD, MEM_WR, WRESP, MEM_RD, RRESP
  } state_t;

  state_t      state;
  logic        aw_captured;
  logic        w_captured;
  logic        read_prio;
  logic        out_en;
  logic [31:0] aw_addr;
  logic [31:0] w_data;

  function automatic logic in_window(input logic [31:0] addr);
    logic [31:0] offset;
    offset = addr - ADDR_BASE;
    return (addr >= ADDR_BASE) && (offset < MEM_BYTES);
  endfunction

  function automatic logic [31:0] word_offset(input logic [31:0] addr);
    return (addr - ADDR_BASE) & 32'hFFFF_FFFC;
  endfunction

  logic        collecting;
  logic        idle_empty;
  logic        wr_req;
  logic        read_block;
  logic        ar_hs;
  logic        aw_hs;
  logic        w_hs;
  logic        aw_have;
  logic        w_have;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  // Round-robin: read_prio names who wins when AR and a write arrive together
  assign collecting = (state == IDLE) || (state == WCOLLECT);
  assign idle_empty = (state == IDLE) && !aw_captured && !w_captured;
  assign wr_req     = s_awvalid || s_wvalid;
  assign read_block = idle_empty && s_arvalid && read_prio;

  assign s_arready = out_en && idle_empty && !(wr_req && !read_prio);
  assign s_awready = out_en && collecting && !aw_captured && !read_block;
  assign s_wready  = out_en && collecting && !w_captured && !read_block;

  assign ar_hs   = s_arvalid && s_arready;
  assign aw_hs   = s_awvalid && s_awready;
  assign w_hs    = s_wvalid && s_wready;
  assign aw_have = aw_captured || aw_hs;
  assign w_have  = w_captured || w_hs;
  assign wr_addr = aw_hs ? s_awaddr : aw_addr;
  assign wr_data = w_hs ? s_wdata : w_data;

`ifdef BRIDGE_WSTRB_EN
  logic [3:0]  w_strb;
  logic [3:0]  wr_strb;
  logic [31:0] merged;

  assign wr_strb = w_hs ? s_wstrb : w_strb;

  always_comb begin
    merged = mem_rdata;
    for (int b = 0; b < 4; b++) begin
      if (w_strb[b]) merged[8*b +: 8] = w_data[8*b +: 8];
    end
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^s_wstrb;
`endif

  always_ff @(posedge clk) begin
    if (res) begin
      state       <= IDLE;
      aw_captured <= 1'b0;
      w_captured  <= 1'b0;
      read_prio   <= 1'b1;
      out_en      <= 1'b0;
      aw_addr     <= 32'h0;
      w_data      <= 32'h0;
`ifdef BRIDGE_WSTRB_EN
      w_strb      <= 4'h0;
`endif
      s_bresp     <= 2'b00;
      s_bvalid    <= 1'b0;
      s_rdata     <= 32'h0;
      s_rresp     <= 2'b00;
      s_rvalid    <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end else begin
      out_en    <= 1'b1;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        IDLE, WCOLLECT: begin
          if (ar_hs) begin
            read_prio <= 1'b0;
            if (in_window(s_araddr)) begin
              mem_addr <= word_offset(s_araddr);
              mem_read <= 1'b1;
              state    <= MEM_RD;
            end else begin
              s_rdata  <= 32'h0;
              s_rresp  <= 2'b10;
              s_rvalid <= 1'b1;
              state    <= RRESP;
            end
          end else if (aw_have && w_have) begin
            aw_captured <= 1'b0;
            w_captured  <= 1'b0;
            read_prio   <= 1'b1;
            if (!in_window(wr_addr)) begin
              s_bresp  <= 2'b10;
              s_bvalid <= 1'b1;
              state    <= WRESP;
            end else begin
              mem_addr <= word_offset(wr_addr);
`ifdef BRIDGE_WSTRB_EN
              w_data <= wr_data;
              w_strb <= wr_strb;
              if (wr_strb == 4'hF) begin
                mem_wdata <= wr_data;
                mem_write <= 1'b1;
                state     <= MEM_WR;
              end else if (wr_strb == 4'h0) begin
                s_bresp  <= 2'b00;
                s_bvalid <= 1'b1;
                state    <= WRESP;
              end else begin
                mem_read <= 1'b1;
                state    <= RMW_RD;
              end
`else
              mem_wdata <= wr_data;
              mem_write <= 1'b1;
              state     <= MEM_WR;
`endif
            end
          end else begin
            if (aw_hs) begin
              aw_captured <= 1'b1;
              aw_addr     <= s_awaddr;
            end
            if (w_hs) begin
              w_captured <= 1'b1;
              w_data     <= s_wdata;
`ifdef BRIDGE_WSTRB_EN
              w_strb     <= s_wstrb;
`endif
            end
            if (aw_have || w_have) state <= WCOLLECT;
          end
        end
`ifdef BRIDGE_WSTRB_EN
        RMW_RD: begin
          if (mem_done) begin
            mem_wdata <= merged;
            mem_write <= 1'b1;
            state     <= MEM_WR;
          end
        end
`endif
        MEM_WR: begin
          if (mem_done) begin
            s_bresp  <= 2'b00;
            s_bvalid <= 1'b1;
            state    <= WRESP;
          end
        end
        WRESP: begin
          if (s_bready) begin
            s_bvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        MEM_RD: begin
          if (mem_done) begin
            s_rdata  <= mem_rdata;
            s_rresp  <= 2'b00;
            s_rvalid <= 1'b1;
            state    <= RRESP;
          end
        end
        RRESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_bram_bridge.sv
// Self-checking bench for axi_lite_bram_bridge: directed vector table, corner sequences,
// and random transactions checked against a word-array reference model.
module tb_axi_lite_bram_bridge;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned BYTES = 65536;
`ifdef BRIDGE_WSTRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [31:0] s_awaddr = 32'h0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = 32'h0;
  logic [3:0]  s_wstrb = 4'h0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b0;
  logic [31:0] s_araddr = 32'h0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_write;
  logic        mem_read;
  logic        mem_done = 1'b0;

  always #5 clk = ~clk;

  axi_lite_bram_bridge #(.ADDR_BASE(BASE), .MEM_BYTES(BYTES)) dut (
    .clk(clk), .res(res),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_done(mem_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Downstream memory: completes each request mem_lat cycles after its pulse
  logic [31:0] bmem [int];
  int          mem_lat = 1;
  bit          inject_done = 1'b0;
  bit          busy = 1'b0;
  bit          busy_wr = 1'b0;
  int          cnt = 0;
  logic [31:0] op_a = 32'h0;
  logic [31:0] op_d = 32'h0;
  int          rd_pulses = 0;
  int          wr_pulses = 0;
  int          overlap = 0;
  int          bvalid_rises = 0;
  int          rvalid_cycles = 0;
  logic [31:0] last_waddr = 32'h0;
  logic [31:0] last_raddr = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  logic        prev_bvalid = 1'b0;

  always @(negedge clk) begin
    mem_done = 1'b0;
    if (busy) begin
      cnt--;
      if (cnt == 0) begin
        busy = 1'b0;
        if (busy_wr) bmem[int'(op_a >> 2)] = op_d;
        else mem_rdata = bmem.exists(int'(op_a >> 2)) ? bmem[int'(op_a >> 2)] : 32'h0;
        mem_done = 1'b1;
      end
    end
    if (inject_done) mem_done = 1'b1;
    if (mem_read || mem_write) begin
      busy    = 1'b1;
      busy_wr = mem_write;
      cnt     = mem_lat;
      op_a    = mem_addr;
      op_d    = mem_wdata;
    end
    if (mem_read) begin
      rd_pulses++;
      last_raddr = mem_addr;
    end
    if (mem_write) begin
      wr_pulses++;
      last_waddr = mem_addr;
      last_wdata = mem_wdata;
    end
    if (mem_read && mem_write) overlap++;
    if (s_bvalid && !prev_bvalid) bvalid_rises++;
    prev_bvalid = s_bvalid;
    if (s_rvalid) rvalid_cycles++;
  end

  // Reference model: a plain word array plus the window/strobe rules
  logic [31:0] ref_mem [int];

  function automatic bit ref_in(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + longint'(BYTES));
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                    output logic [1:0] resp, output int n_rd, output int n_wr);
    int k;
    logic [31:0] w;
    n_rd = 0;
    n_wr = 0;
    resp = 2'b00;
    if (!ref_in(a)) begin
      resp = 2'b10;
      return;
    end
    if (STRB_EN && s == 4'h0) return;
    k = int'((a - BASE) / 4);
    w = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    for (int b = 0; b < 4; b++) if (!STRB_EN || s[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[k] = w;
    n_wr = 1;
    n_rd = (STRB_EN && s != 4'hF) ? 1 : 0;
  endfunction

  function automatic void ref_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp, output int n_rd);
    int k;
    d = 32'h0;
    resp = 2'b10;
    n_rd = 0;
    if (!ref_in(a)) return;
    k = int'((a - BASE) / 4);
    d = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    resp = 2'b00;
    n_rd = 1;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
    int cyc;
    int seen;
    bit aw_done, w_done, aw_now, w_now;
    cyc = 0; aw_done = 0; w_done = 0; resp = 2'bxx;
    s_awaddr = a; s_wdata = d; s_wstrb = s;
    while (!(aw_done && w_done) && cyc < 100) begin
      s_awvalid = !aw_done && cyc >= aw_dly;
      s_wvalid  = !w_done && cyc >= w_dly;
      @(negedge clk);
      aw_now = s_awvalid && s_awready;
      w_now  = s_wvalid && s_wready;
      @(posedge clk); #1;
      aw_done |= aw_now;
      w_done  |= w_now;
      cyc++;
    end
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    check_output("wr_accepted", 32'(aw_done && w_done), 32'h1);
    seen = 0; cyc = 0;
    while (cyc < 100) begin
      s_bready = (seen >= b_dly);
      @(negedge clk);
      if (s_bvalid && s_bready) begin
        resp = s_bresp;
        @(posedge clk); #1;
        break;
      end
      if (s_bvalid) seen++;
      @(posedge clk); #1;
      cyc++;
    end
    s_bready = 1'b0;
    check_output("wr_resp_in_time", 32'(cyc < 100), 32'h1);
  endtask

  task automatic do_read(input logic [31:0] a, input int r_dly, output logic [31:0] d, output logic [1:0] resp);
    int cyc;
    int seen;
    bit ar_done, ar_now;
    cyc = 0; ar_done = 0; d = 'x; resp = 2'bxx;
    s_araddr = a;
    while (!ar_done && cyc < 100) begin
      s_arvalid = 1'b1;
      @(negedge clk);
      ar_now = s_arready;
      @(posedge clk); #1;
      ar_done = ar_now;
      cyc++;
    end
    s_arvalid = 1'b0;
    check_output("rd_accepted", 32'(ar_done), 32'h1);
    seen = 0; cyc = 0;
    while (cyc < 100) begin
      s_rready = (seen >= r_dly);
      @(negedge clk);
      if (s_rvalid && s_rready) begin
        d = s_rdata;
        resp = s_rresp;
        @(posedge clk); #1;
        break;
      end
      if (s_rvalid) seen++;
      @(posedge clk); #1;
      cyc++;
    end
    s_rready = 1'b0;
    check_output("rd_resp_in_time", 32'(cyc < 100), 32'h1);
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_flags"}, 32'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
                                       mem_read, mem_write, s_bresp, s_rresp}), 32'h0);
    check_output({tag, "_rdata"}, s_rdata, 32'h0);
    check_output({tag, "_mem_addr"}, mem_addr, 32'h0);
    check_output({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  task automatic do_reset();
    res = 1'b1;
    s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0; s_rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    res = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          n_rd;
    int          n_wr;
    logic [31:0] maddr;
    logic [31:0] mwdata;
  } vec_t;

  task automatic apply_stimulus(input vec_t v, input int idx);
    int rd0, wr0, m_rd, m_wr;
    logic [1:0]  resp, ref_resp;
    logic [31:0] d;
    rd0 = rd_pulses;
    wr0 = wr_pulses;
    if (v.wr) begin
      ref_write(v.addr, v.data, v.strb, ref_resp, m_rd, m_wr);
      do_write(v.addr, v.data, v.strb, idx % 3, (idx + 1) % 3, idx % 2, resp);
      check_output($sformatf("vec%0d_bresp", idx), 32'(resp), 32'(v.resp));
      if (v.n_wr > 0) begin
        check_output($sformatf("vec%0d_mem_addr", idx), last_waddr, v.maddr);
        check_output($sformatf("vec%0d_mem_wdata", idx), last_wdata, v.mwdata);
      end
    end else begin
      do_read(v.addr, idx % 2, d, resp);
      check_output($sformatf("vec%0d_rresp", idx), 32'(resp), 32'(v.resp));
      check_output($sformatf("vec%0d_rdata", idx), d, v.rdata);
      if (v.n_rd > 0) check_output($sformatf("vec%0d_rd_addr", idx), last_raddr, v.maddr);
    end
    check_output($sformatf("vec%0d_rd_pulses", idx), 32'(rd_pulses - rd0), 32'(v.n_rd));
    check_output($sformatf("vec%0d_wr_pulses", idx), 32'(wr_pulses - wr0), 32'(v.n_wr));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        tbl[$];
    logic [1:0]  resp, eresp;
    logic [31:0] d, ed, a;
    logic [3:0]  s;
    int          n, cyc, rd0, wr0, b0, r0, e_rd, e_wr, hold_cnt, ar_cnt;
    bit          got;
    logic [2:0]  grant;

    tbl.push_back('{1, 32'h10,    32'hDEADBEEF, 4'hF, 2'b00, 32'h0, 0, 1, 32'h10, 32'hDEADBEEF});
    tbl.push_back('{0, 32'h10,    32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 1, 0, 32'h10, 32'h0});
    tbl.push_back('{1, 32'h8,     32'h11223344, 4'hF, 2'b00, 32'h0, 0, 1, 32'h8, 32'h11223344});
    tbl.push_back('{1, 32'h8,     32'hAABBCCDD, 4'h5, 2'b00, 32'h0, STRB_EN ? 1 : 0, 1, 32'h8,
                    STRB_EN ? 32'h11BB33DD : 32'hAABBCCDD});
    tbl.push_back('{0, 32'h8,     32'h0,        4'h0, 2'b00, STRB_EN ? 32'h11BB33DD : 32'hAABBCCDD, 1, 0, 32'h8, 32'h0});
    tbl.push_back('{0, 32'h10000, 32'h0,        4'h0, 2'b10, 32'h0, 0, 0, 32'h0, 32'h0});
    tbl.push_back('{1, 32'h10000, 32'h12,       4'hF, 2'b10, 32'h0, 0, 0, 32'h0, 32'h0});
    tbl.push_back('{1, 32'hFFFC,  32'hCAFEF00D, 4'hF, 2'b00, 32'h0, 0, 1, 32'hFFFC, 32'hCAFEF00D});
    tbl.push_back('{0, 32'hFFFC,  32'h0,        4'h0, 2'b00, 32'hCAFEF00D, 1, 0, 32'hFFFC, 32'h0});
    tbl.push_back('{1, 32'h13,    32'h01020304, 4'hF, 2'b00, 32'h0, 0, 1, 32'h10, 32'h01020304});
    tbl.push_back('{0, 32'h11,    32'h0,        4'h0, 2'b00, 32'h01020304, 1, 0, 32'h10, 32'h0});
    tbl.push_back('{1, 32'h10,    32'h55555555, 4'h0, 2'b00, 32'h0, 0, STRB_EN ? 0 : 1, 32'h10, 32'h55555555});
    tbl.push_back('{0, 32'h10,    32'h0,        4'h0, 2'b00, STRB_EN ? 32'h01020304 : 32'h55555555, 1, 0, 32'h10, 32'h0});
    tbl.push_back('{1, 32'h20,    32'hA5A5A5A5, 4'h8, 2'b00, 32'h0, STRB_EN ? 1 : 0, 1, 32'h20,
                    STRB_EN ? 32'hA5000000 : 32'hA5A5A5A5});

    res = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    res = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) apply_stimulus(tbl[i], i);

    // W accepted two cycles ahead of AW still yields exactly one write and one response
    wr0 = wr_pulses; b0 = bvalid_rises;
    ref_write(32'h4, 32'h12345678, 4'hF, eresp, e_rd, e_wr);
    do_write(32'h4, 32'h12345678, 4'hF, 2, 0, 0, resp);
    repeat (3) @(posedge clk);
    #1;
    check_output("w_first_bresp", 32'(resp), 32'h0);
    check_output("w_first_wr_pulses", 32'(wr_pulses - wr0), 32'h1);
    check_output("w_first_wdata", last_wdata, 32'h12345678);
    check_output("w_first_bvalid_count", 32'(bvalid_rises - b0), 32'h1);

    // Read latency from AR handshake to rvalid with a one-cycle memory
    mem_lat = 1;
    s_araddr = 32'h4; s_arvalid = 1'b1; got = 0; cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      got = s_arready;
      @(posedge clk); #1;
      cyc++;
    end
    s_arvalid = 1'b0;
    n = 0;
    while (!s_rvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("read_latency", 32'(n), 32'h2);
    check_output("read_latency_data", s_rdata, 32'h12345678);
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;

    // Stray mem_done while idle must not produce a response
    r0 = rvalid_cycles; b0 = bvalid_rises;
    @(posedge clk); #1;
    inject_done = 1'b1;
    @(posedge clk); #1;
    inject_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("stray_done_rvalid", 32'(rvalid_cycles - r0), 32'h0);
    check_output("stray_done_bvalid", 32'(bvalid_rises - b0), 32'h0);
    check_output("stray_done_idle", 32'(s_arready), 32'h1);

    // Simultaneous AR and write after reset: read first, then write, then held read
    do_reset();
    wr0 = wr_pulses;
    s_araddr = 32'h10; s_awaddr = 32'h20; s_wdata = 32'h0BADCAFE; s_wstrb = 4'hF;
    s_arvalid = 1'b1; s_awvalid = 1'b1; s_wvalid = 1'b1; s_rready = 1'b1; s_bready = 1'b0;
    got = 0; cyc = 0; grant = 3'b000;
    while (!got && cyc < 20) begin
      @(negedge clk);
      if (s_arready || s_awready || s_wready) begin
        got = 1;
        grant = {s_arready, s_awready, s_wready};
      end
      @(posedge clk); #1;
      cyc++;
    end
    check_output("arb_first_grant", 32'(grant), 32'h4);
    cyc = 0;
    while (!s_rvalid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    ref_read(32'h10, ed, eresp, e_rd);
    check_output("arb_read_data", s_rdata, ed);
    @(posedge clk); #1;
    got = 0; cyc = 0; grant = 3'b000;
    while (!got && cyc < 20) begin
      @(negedge clk);
      if (s_arready || s_awready || s_wready) begin
        got = 1;
        grant = {s_arready, s_awready, s_wready};
      end
      @(posedge clk); #1;
      cyc++;
    end
    check_output("arb_second_grant", 32'(grant), 32'h3);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    ref_write(32'h20, 32'h0BADCAFE, 4'hF, eresp, e_rd, e_wr);
    cyc = 0;
    while (!s_bvalid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    hold_cnt = 0; ar_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      hold_cnt += int'(s_bvalid);
      ar_cnt += int'(s_arready);
      @(posedge clk); #1;
    end
    check_output("bvalid_held", 32'(hold_cnt), 32'h5);
    check_output("no_arready_in_wresp", 32'(ar_cnt), 32'h0);
    s_bready = 1'b1;
    @(negedge clk);
    check_output("arb_bresp", 32'({s_bvalid, s_bresp}), 32'h4);
    @(posedge clk); #1;
    s_bready = 1'b0;
    check_output("arb_wr_pulses", 32'(wr_pulses - wr0), 32'h1);
    got = 0; cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      got = s_arready;
      @(posedge clk); #1;
      cyc++;
    end
    s_arvalid = 1'b0;
    cyc = 0;
    while (!s_rvalid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_output("arb_held_read_data", s_rdata, ed);
    @(posedge clk); #1;
    s_rready = 1'b0;

    // Reset while waiting in MEM_RD: abandon, ignore late mem_done
    mem_lat = 4;
    s_araddr = 32'h20; s_arvalid = 1'b1; got = 0; cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      got = s_arready;
      @(posedge clk); #1;
      cyc++;
    end
    s_arvalid = 1'b0;
    s_rready = 1'b1;
    @(posedge clk); #1;
    res = 1'b1;
    @(posedge clk); #1;
    check_reset_state("mid_read_reset");
    res = 1'b0;
    r0 = rvalid_cycles;
    repeat (10) @(posedge clk);
    #1;
    check_output("late_done_no_rvalid", 32'(rvalid_cycles - r0), 32'h0);
    s_rready = 1'b0;

    // Randomized transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      mem_lat = $urandom_range(1, 3);
      n = $urandom_range(0, 9);
      if (n < 7) a = 32'($urandom_range(0, 63));
      else if (n == 7) a = 32'hFFF0 + 32'($urandom_range(0, 31));
      else if (n == 8) a = 32'h10000 + 32'($urandom_range(0, 255));
      else a = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
      rd0 = rd_pulses; wr0 = wr_pulses;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        ref_write(a, d, s, eresp, e_rd, e_wr);
        do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), resp);
        check_output($sformatf("rnd%0d_bresp", i), 32'(resp), 32'(eresp));
        check_output($sformatf("rnd%0d_wr_pulses", i), 32'(wr_pulses - wr0), 32'(e_wr));
        check_output($sformatf("rnd%0d_rmw_pulses", i), 32'(rd_pulses - rd0), 32'(e_rd));
      end else begin
        ref_read(a, ed, eresp, e_rd);
        do_read(a, $urandom_range(0, 2), d, resp);
        check_output($sformatf("rnd%0d_rresp", i), 32'(resp), 32'(eresp));
        check_output($sformatf("rnd%0d_rdata", i), d, ed);
        check_output($sformatf("rnd%0d_rd_pulses", i), 32'(rd_pulses - rd0), 32'(e_rd));
      end
    end

    check_output("mem_rd_wr_overlap", 32'(overlap), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
